bus_arbiter: RTL and testbench

- Registered two-requester arbiter that shares the single external memory port between instruction fetch and data load/store.
- Sits between the core's fetch/memory stages and the external bus.
- Latches each granted request and holds it stable on the bus until the external handshake completes. Returns the response to the owning requester as a one-cycle ready pulse.
- Gives data priority over fetch, bounded by an anti-starvation counter so fetch is never locked out.

---
 rtl/bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: registered two-requester arbiter sharing one external memory
// port between instruction fetch and data load/store. Data has priority over
// fetch, bounded by an 8-bit starvation counter. Optional bus watchdog is
// enabled by defining the macro BUS_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transaction on the bus; arbitration happens here
// FETCH | fetch transaction held on the bus until ext_ready
// DATA  | data transaction held on the bus until ext_ready
module bus_arbiter #(
    parameter int FETCH_STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_address,
    output logic        fetch_ready,
    output logic [31:0] fetch_data,
    input  logic        mem_valid,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic [3:0]  mem_write_strobe,
    output logic        mem_ready,
    output logic [31:0] mem_read_data,
    output logic        ext_valid,
    output logic        ext_instruction,
    output logic [31:0] ext_address,
    output logic [31:0] ext_write_data,
    output logic [3:0]  ext_write_strobe,
    input  logic        ext_ready,
    input  logic [31:0] ext_read_data,
    output logic        busy,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam logic [7:0] LP_STARVE_LIMIT = 8'(FETCH_STARVE_LIMIT);

    state_t      r_state;
    logic [7:0]  r_starve_cnt;
    logic        r_ext_valid;
    logic        r_ext_instruction;
    logic [31:0] r_ext_address;
    logic [31:0] r_ext_write_data;
    logic [3:0]  r_ext_write_strobe;
    logic        r_fetch_ready;
    logic [31:0] r_fetch_data;
    logic        r_mem_ready;
    logic [31:0] r_mem_read_data;
    logic        r_bus_error;

    logic        w_fetch_req;
    logic        w_mem_req;
    logic        w_grant_data;
    logic        w_grant_fetch;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_resp_data;

    // A port whose ready pulse is high is presenting its completed request.
    assign w_fetch_req   = fetch_valid & ~r_fetch_ready;
    assign w_mem_req     = mem_valid & ~r_mem_ready;
    assign w_grant_data  = w_mem_req & (~w_fetch_req | (r_starve_cnt < LP_STARVE_LIMIT));
    assign w_grant_fetch = w_fetch_req & ~w_grant_data;
    assign w_done        = ext_ready | w_timeout;
    assign w_resp_data   = ext_ready ? ext_read_data : 32'h0;

`ifdef BUS_TIMEOUT_EN
    localparam logic [15:0] LP_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wait_cnt;

    // Watchdog: counts bus cycles without ext_ready, cleared while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= 16'd0;
        end else if (r_state == IDLE) begin
            r_wait_cnt <= 16'd0;
        end else if (!ext_ready) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state != IDLE) & ~ext_ready & (r_wait_cnt == LP_TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    // Arbitration FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= IDLE;
            r_starve_cnt       <= 8'd0;
            r_ext_valid        <= 1'b0;
            r_ext_instruction  <= 1'b0;
            r_ext_address      <= 32'h0;
            r_ext_write_data   <= 32'h0;
            r_ext_write_strobe <= 4'h0;
            r_fetch_ready      <= 1'b0;
            r_fetch_data       <= 32'h0;
            r_mem_ready        <= 1'b0;
            r_mem_read_data    <= 32'h0;
            r_bus_error        <= 1'b0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_mem_ready   <= 1'b0;
            r_bus_error   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_data) begin
                        r_state            <= DATA;
                        r_ext_valid        <= 1'b1;
                        r_ext_instruction  <= 1'b0;
                        r_ext_address      <= {mem_address[31:2], 2'b00};
                        r_ext_write_data   <= mem_write_data;
                        r_ext_write_strobe <= mem_write_strobe;
                        if (w_fetch_req) begin
                            if (r_starve_cnt != 8'hff) begin
                                r_starve_cnt <= r_starve_cnt + 8'd1;
                            end
                        end else begin
                            r_starve_cnt <= 8'd0;
                        end
                    end else if (w_grant_fetch) begin
                        r_state            <= FETCH;
                        r_ext_valid        <= 1'b1;
                        r_ext_instruction  <= 1'b1;
                        r_ext_address      <= {fetch_address[31:2], 2'b00};
                        r_ext_write_data   <= 32'h0;
                        r_ext_write_strobe <= 4'h0;
                        r_starve_cnt       <= 8'd0;
                    end
                end
                FETCH, DATA: begin
                    if (w_done) begin
                        r_state     <= IDLE;
                        r_ext_valid <= 1'b0;
                        r_bus_error <= w_timeout;
                        if (r_state == FETCH) begin
                            r_fetch_ready <= 1'b1;
                            r_fetch_data  <= w_resp_data;
                        end else begin
                            r_mem_ready     <= 1'b1;
                            r_mem_read_data <= w_resp_data;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_ext_valid <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_ready      = r_fetch_ready;
    assign fetch_data       = r_fetch_data;
    assign mem_ready        = r_mem_ready;
    assign mem_read_data    = r_mem_read_data;
    assign ext_valid        = r_ext_valid;
    assign ext_instruction  = r_ext_instruction;
    assign ext_address      = r_ext_address;
    assign ext_write_data   = r_ext_write_data;
    assign ext_write_strobe = r_ext_write_strobe;
    assign busy             = (r_state != IDLE);
    assign bus_error        = r_bus_error;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level reference model. Define
// BUS_TIMEOUT_EN to exercise the watchdog (TIMEOUT_CYCLES = 8).
module tb_bus_arbiter;

    localparam int LIMIT = 4;
`ifdef BUS_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_address = 32'h0;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_address = 32'h0;
    logic [31:0] mem_write_data = 32'h0;
    logic [3:0]  mem_write_strobe = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_read_data;
    logic        ext_valid;
    logic        ext_instruction;
    logic [31:0] ext_address;
    logic [31:0] ext_write_data;
    logic [3:0]  ext_write_strobe;
    logic        ext_ready = 1'b0;
    logic [31:0] ext_read_data = 32'h0;
    logic        busy;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.FETCH_STARVE_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .mem_valid(mem_valid), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write_strobe(mem_write_strobe),
        .mem_ready(mem_ready), .mem_read_data(mem_read_data),
        .ext_valid(ext_valid), .ext_instruction(ext_instruction),
        .ext_address(ext_address), .ext_write_data(ext_write_data),
        .ext_write_strobe(ext_write_strobe), .ext_ready(ext_ready),
        .ext_read_data(ext_read_data), .busy(busy), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, the request it carries, how many
    // cycles it has been on the bus, and the last response seen per port.
    int          m_owner;    // 0 none, 1 fetch, 2 data
    int          m_elapsed;  // bus cycles already spent without ext_ready
    int          m_starve;
    logic [31:0] m_addr, m_wd, m_fdata, m_mdata;
    logic [3:0]  m_ws;
    logic        m_fready, m_mready, m_err, m_instr;

    task automatic model_reset();
        m_owner = 0; m_elapsed = 0; m_starve = 0;
        m_addr = 0; m_wd = 0; m_fdata = 0; m_mdata = 0; m_ws = 0;
        m_fready = 0; m_mready = 0; m_err = 0; m_instr = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ext_valid", {31'b0, ext_valid}, {31'b0, m_owner != 0});
        chk("ext_instruction", {31'b0, ext_instruction}, {31'b0, m_instr});
        chk("ext_address", ext_address, m_addr);
        chk("ext_write_data", ext_write_data, m_wd);
        chk("ext_write_strobe", {28'b0, ext_write_strobe}, {28'b0, m_ws});
        chk("fetch_ready", {31'b0, fetch_ready}, {31'b0, m_fready});
        chk("fetch_data", fetch_data, m_fdata);
        chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_mready});
        chk("mem_read_data", mem_read_data, m_mdata);
        chk("busy", {31'b0, busy}, {31'b0, m_owner != 0});
        chk("bus_error", {31'b0, bus_error}, {31'b0, m_err});
        chk("starve_cnt", {24'b0, dut.r_starve_cnt}, 32'(m_starve));
    endtask

    // Advance one clock: predict the model outcome from the current inputs,
    // clock the DUT, then compare at the falling edge.
    task automatic tick();
        bit          f_pend, d_pend, finished, timed_out;
        logic [31:0] resp;
        f_pend = fetch_valid && !m_fready;
        d_pend = mem_valid && !m_mready;
        @(posedge clk);
        m_fready = 0; m_mready = 0; m_err = 0;
        if (m_owner == 0) begin
            if (d_pend && (!f_pend || m_starve < LIMIT)) begin
                m_owner = 2; m_elapsed = 0; m_instr = 0;
                m_addr = mem_address & 32'hffff_fffc;
                m_wd = mem_write_data; m_ws = mem_write_strobe;
                m_starve = f_pend ? ((m_starve + 1 > 255) ? 255 : m_starve + 1) : 0;
            end else if (f_pend) begin
                m_owner = 1; m_elapsed = 0; m_instr = 1;
                m_addr = fetch_address & 32'hffff_fffc;
                m_wd = 0; m_ws = 0; m_starve = 0;
            end
        end else begin
            finished = ext_ready;
            timed_out = 0;
`ifdef BUS_TIMEOUT_EN
            if (!ext_ready && m_elapsed + 1 >= TO) timed_out = 1;
`endif
            if (finished || timed_out) begin
                resp = finished ? ext_read_data : 32'h0;
                if (m_owner == 1) begin m_fready = 1; m_fdata = resp; end
                else begin m_mready = 1; m_mdata = resp; end
                m_err = timed_out;
                m_owner = 0;
            end else begin
                m_elapsed++;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Requester behaviour: hold valid while owning the bus, otherwise random.
    task automatic drive_random(input int ready_pct);
        if (m_owner == 1) fetch_valid = 1'b1;
        else fetch_valid = ($urandom_range(0, 2) != 0);
        fetch_address = $urandom();
        if (m_owner == 2) mem_valid = 1'b1;
        else mem_valid = ($urandom_range(0, 2) != 0);
        mem_address = $urandom();
        mem_write_data = $urandom();
        mem_write_strobe = 4'($urandom_range(0, 15));
        ext_ready = ($urandom_range(0, 99) < ready_pct);
        ext_read_data = $urandom();
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            fetch_valid = (m_owner == 1);
            mem_valid = (m_owner == 2);
            ext_ready = 1'b1;
            ext_read_data = $urandom();
            tick();
        end
        ext_ready = 1'b0;
    endtask

    initial begin
        int  ndata, nvalid;
        bit  seen, prev_ev;
        model_reset();

        // Reset state
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Single fetch with bus response two cycles after ext_valid
        fetch_valid = 1'b1; fetch_address = 32'h0000_1006;
        tick();
        chk("t1_addr", ext_address, 32'h0000_1004);
        chk("t1_instr", {31'b0, ext_instruction}, 32'd1);
        chk("t1_strobe", {28'b0, ext_write_strobe}, 32'd0);
        tick();
        tick();
        ext_ready = 1'b1; ext_read_data = 32'hDEAD_BEEF;
        tick();
        chk("t1_fready", {31'b0, fetch_ready}, 32'd1);
        chk("t1_fdata", fetch_data, 32'hDEAD_BEEF);
        fetch_valid = 1'b0; ext_ready = 1'b0;
        tick();
        chk("t1_fready_once", {31'b0, fetch_ready}, 32'd0);

        // Simultaneous requests: data first, fetch granted during mem_ready
        fetch_valid = 1'b1; fetch_address = 32'h0000_2000;
        mem_valid = 1'b1; mem_address = 32'h0000_3003;
        mem_write_data = 32'h1234_5678; mem_write_strobe = 4'b0011;
        tick();
        chk("t2_instr", {31'b0, ext_instruction}, 32'd0);
        chk("t2_strobe", {28'b0, ext_write_strobe}, 32'd3);
        ext_ready = 1'b1; ext_read_data = 32'h5555_AAAA;
        tick();
        chk("t2_mready", {31'b0, mem_ready}, 32'd1);
        ext_ready = 1'b0;
        tick();
        chk("t2_fetch_granted", {31'b0, ext_valid & ext_instruction}, 32'd1);
        mem_valid = 1'b0;
        drain();

        // Starvation: data always requesting, fetch withdrawn only while
        // mem_ready is high, so fetch is pending at every data grant.
        ndata = 0; seen = 0; prev_ev = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            mem_valid = 1'b1; mem_address = $urandom(); mem_write_strobe = 4'h0;
            fetch_valid = !m_mready; fetch_address = 32'h0000_4000;
            ext_ready = 1'b1; ext_read_data = $urandom();
            tick();
            if (ext_valid && !prev_ev) begin
                if (ext_instruction) seen = 1;
                else ndata++;
            end
            prev_ev = ext_valid;
        end
        chk("t3_fetch_seen", {31'b0, seen}, 32'd1);
        chk("t3_data_grants", 32'(ndata), 32'(LIMIT));
        chk("t3_starve_zero", {24'b0, dut.r_starve_cnt}, 32'd0);
        mem_valid = 1'b0;
        drain();

        // Reset while a data transaction is on the bus
        mem_valid = 1'b1; mem_address = 32'h0000_5000; ext_ready = 1'b0;
        tick();
        chk("t4_ev_before", {31'b0, ext_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t4_ev_async", {31'b0, ext_valid}, 32'd0);
        chk("t4_busy_async", {31'b0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b0; mem_valid = 1'b0; ext_ready = 1'b1;
        tick();
        tick();
        chk("t4_no_mready", {31'b0, mem_ready}, 32'd0);
        ext_ready = 1'b0;

`ifdef BUS_TIMEOUT_EN
        // Watchdog expiry
        nvalid = 0; seen = 0;
        mem_valid = 1'b1; mem_address = 32'h0000_6000; ext_ready = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (mem_ready) seen = 1;
            else if (ext_valid) nvalid++;
        end
        chk("t5_done", {31'b0, seen}, 32'd1);
        chk("t5_valid_cycles", 32'(nvalid), 32'(TO));
        chk("t5_bus_error", {31'b0, bus_error}, 32'd1);
        chk("t5_rdata", mem_read_data, 32'h0);
        mem_valid = 1'b0;
        tick();
        chk("t5_err_pulse", {31'b0, bus_error}, 32'd0);

        // ext_ready on the last permitted cycle completes normally
        mem_valid = 1'b1; mem_address = 32'h0000_7000;
        tick();
        repeat (TO - 1) tick();
        ext_ready = 1'b1; ext_read_data = 32'hCAFE_F00D;
        tick();
        chk("t6_mready", {31'b0, mem_ready}, 32'd1);
        chk("t6_no_error", {31'b0, bus_error}, 32'd0);
        chk("t6_rdata", mem_read_data, 32'hCAFE_F00D);
        mem_valid = 1'b0; ext_ready = 1'b0;
        tick();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive_random(i < 300 ? 40 : 8);
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
